// File: rtl/conv3x3_layer_mc_if.sv
// rtl/conv3x3_layer_mc_if.sv - pixel/weight/result bundle for the multi-channel 3x3 conv layer
interface conv3x3_layer_mc_if #(
  parameter int DATA_W = 16,
  parameter int OUT_CH = 4,
  parameter int ACC_W  = 2*DATA_W+4
);
  logic                       start;
  logic                       relu_en;
  logic [OUT_CH*9*DATA_W-1:0] weights;
  logic [DATA_W-1:0]          pix_in;
  logic                       pix_valid;
  logic [OUT_CH*ACC_W-1:0]    data_out;
  logic                       out_valid;
  logic                       busy;
  logic                       frame_done;

  modport master (
    output start, relu_en, weights, pix_in, pix_valid,
    input  data_out, out_valid, busy, frame_done
  );

  modport slave (
    input  start, relu_en, weights, pix_in, pix_valid,
    output data_out, out_valid, busy, frame_done
  );
endinterface

// File: rtl/conv3x3_layer_mc.sv
// rtl/conv3x3_layer_mc.sv - streaming 3x3 valid convolution, OUT_CH parallel channels, optional ReLU
module conv3x3_layer_mc #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int OUT_CH = 4,
  parameter int ACC_W  = 2*DATA_W+4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  conv3x3_layer_mc_if.slave bus_if
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = 2*DATA_W;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W-1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H-1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t                     state_q;
  logic                       busy_q;
  logic                       relu_q;
  logic [OUT_CH*9*DATA_W-1:0] weights_q;
  logic [CW-1:0]              col_q;
  logic [RW-1:0]              row_q;

  logic signed [DATA_W-1:0] lb0_q [IMG_W];
  logic signed [DATA_W-1:0] lb1_q [IMG_W];
  logic signed [DATA_W-1:0] sw_q  [9];
  logic signed [DATA_W-1:0] win_q [9];
  logic signed [PW-1:0]     prod_q [OUT_CH*9];
  logic                     sw_vld_q, sw_last_q;
  logic                     win_vld_q, win_last_q;
  logic                     prod_vld_q, prod_last_q;
  logic [OUT_CH*ACC_W-1:0]  data_out_q;
  logic                     out_valid_q;
  logic                     frame_done_q;

  logic signed [ACC_W-1:0]  sum_c [OUT_CH];

  logic accept;
  logic last_pix;
  logic emit;

  assign accept   = (state_q == S_RUN) && bus_if.pix_valid;
  assign last_pix = accept && (col_q == LAST_COL) && (row_q == LAST_ROW);
  assign emit     = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

  function automatic logic signed [PW-1:0] smul(input logic signed [DATA_W-1:0] a,
                                                 input logic signed [DATA_W-1:0] b);
    logic signed [PW-1:0] ae;
    logic signed [PW-1:0] be;
    ae = {{DATA_W{a[DATA_W-1]}}, a};
    be = {{DATA_W{b[DATA_W-1]}}, b};
    return ae * be;
  endfunction

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [PW-1:0] p);
    return {{(ACC_W-PW){p[PW-1]}}, p};
  endfunction

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      relu_q    <= 1'b0;
      weights_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus_if.start) begin
            state_q   <= S_RUN;
            busy_q    <= 1'b1;
            relu_q    <= bus_if.relu_en;
            weights_q <= bus_if.weights;
            col_q     <= '0;
            row_q     <= '0;
          end
        end
        S_RUN: begin
          if (last_pix) begin
            state_q <= S_FLUSH;
            col_q   <= '0;
            row_q   <= '0;
          end else if (accept) begin
            if (col_q == LAST_COL) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          // Leave in the same cycle the last result is presented.
          if (frame_done_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Line buffers hold the previous two rows at each column; no reset needed.
  always_ff @(posedge sys_clk) begin
    if (accept) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= bus_if.pix_in;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < 9; i++) begin
        sw_q[i]  <= '0;
        win_q[i] <= '0;
      end
      for (int i = 0; i < OUT_CH*9; i++) prod_q[i] <= '0;
      sw_vld_q     <= 1'b0;
      sw_last_q    <= 1'b0;
      win_vld_q    <= 1'b0;
      win_last_q   <= 1'b0;
      prod_vld_q   <= 1'b0;
      prod_last_q  <= 1'b0;
      data_out_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          sw_q[3*r]   <= sw_q[3*r+1];
          sw_q[3*r+1] <= sw_q[3*r+2];
        end
        sw_q[2] <= lb1_q[col_q];
        sw_q[5] <= lb0_q[col_q];
        sw_q[8] <= bus_if.pix_in;
      end
      sw_vld_q  <= emit;
      sw_last_q <= last_pix;

      if (sw_vld_q) begin
        for (int i = 0; i < 9; i++) win_q[i] <= sw_q[i];
      end
      win_vld_q  <= sw_vld_q;
      win_last_q <= sw_last_q;

      if (win_vld_q) begin
        for (int ch = 0; ch < OUT_CH; ch++) begin
          for (int k = 0; k < 9; k++) begin
            prod_q[ch*9+k] <= smul(win_q[k], weights_q[(ch*9+k)*DATA_W +: DATA_W]);
          end
        end
      end
      prod_vld_q  <= win_vld_q;
      prod_last_q <= win_last_q;

      if (prod_vld_q) begin
        for (int ch = 0; ch < OUT_CH; ch++) begin
          data_out_q[ch*ACC_W +: ACC_W] <= (relu_q && sum_c[ch][ACC_W-1]) ? '0 : sum_c[ch];
        end
      end
      out_valid_q  <= prod_vld_q;
      frame_done_q <= prod_vld_q && prod_last_q;
    end
  end

  always_comb begin
    for (int ch = 0; ch < OUT_CH; ch++) begin
      sum_c[ch] = '0;
      for (int k = 0; k < 9; k++) sum_c[ch] = sum_c[ch] + sext(prod_q[ch*9+k]);
    end
  end

  assign bus_if.data_out   = data_out_q;
  assign bus_if.out_valid  = out_valid_q;
  assign bus_if.busy       = busy_q;
  assign bus_if.frame_done = frame_done_q;

endmodule

// File: tb/tb_conv3x3_layer_mc.sv
// tb/tb_conv3x3_layer_mc.sv - directed self-checking bench for conv3x3_layer_mc (5x4 image, 2 channels)
module tb_conv3x3_layer_mc;

  localparam int DW = 8;
  localparam int IW = 5;
  localparam int IH = 4;
  localparam int OC = 2;
  localparam int AW = 20;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  conv3x3_layer_mc_if #(.DATA_W(DW), .OUT_CH(OC), .ACC_W(AW)) bus ();

  conv3x3_layer_mc #(
    .DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .OUT_CH(OC), .ACC_W(AW)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus_if  (bus.slave)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  int cap0[$];
  int cap1[$];
  int cap_cyc[$];
  int fd_cnt = 0;
  int fd_cyc = -1;
  int orphan_fd = 0;
  int acc22 = 0;

  int seq0[6] = '{6, 7, 8, 11, 12, 13};
  int seq1[6] = '{0, 2, 4, 10, 12, 14};

  logic signed [AW-1:0] mon0, mon1;
  always @(negedge sys_clk) begin
    if (bus.out_valid) begin
      mon0 = bus.data_out[AW-1:0];
      mon1 = bus.data_out[2*AW-1:AW];
      cap0.push_back(int'(mon0));
      cap1.push_back(int'(mon1));
      cap_cyc.push_back(cyc);
    end
    if (bus.frame_done) begin
      fd_cnt <= fd_cnt + 1;
      fd_cyc <= cyc;
      if (!bus.out_valid) orphan_fd <= orphan_fd + 1;
    end
  end

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_w(input int ch, input int k, input int val);
    logic [DW-1:0] v;
    v = val[DW-1:0];
    bus.weights[(ch*9+k)*DW +: DW] = v;
  endtask

  task automatic w_pm1();
    for (int k = 0; k < 9; k++) begin
      set_w(0, k, 1);
      set_w(1, k, -1);
    end
  endtask

  task automatic w_seq();
    bus.weights = '0;
    set_w(0, 4, 1);
    set_w(1, 0, 2);
  endtask

  task automatic pulse_start(input logic relu);
    bus.relu_en = relu;
    bus.start   = 1'b1;
    @(posedge sys_clk); #1;
    bus.start   = 1'b0;
  endtask

  // pat 0: all ones, pat 1: 5*row+col. gaps inserts two idle cycles between pixels.
  task automatic send_frame(input int pat, input bit gaps, input bit disturb, input int npix);
    for (int idx = 0; idx < npix; idx++) begin
      int r, c;
      r = idx / IW;
      c = idx % IW;
      if (gaps && idx > 0) begin
        for (int g = 0; g < 2; g++) begin
          bus.pix_valid = 1'b0;
          bus.pix_in    = 8'hAA;
          if (disturb && idx == 7 && g == 0) begin
            bus.weights = '0;
            bus.relu_en = 1'b1;
            bus.start   = 1'b1;
          end
          @(posedge sys_clk); #1;
          bus.start = 1'b0;
        end
      end
      bus.pix_valid = 1'b1;
      bus.pix_in    = (pat == 0) ? 8'd1 : 8'(5*r + c);
      if (disturb && idx == 12) bus.start = 1'b1;
      @(posedge sys_clk); #1;
      bus.start = 1'b0;
      if (r == 2 && c == 2) acc22 = cyc;
    end
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
  endtask

  task automatic wait_done(input string tag, input int fdb);
    int n;
    n = 0;
    while (fd_cnt == fdb && n < 60) begin
      @(negedge sys_clk); #1;
      n++;
    end
    check({tag, "_done_seen"}, fd_cnt - fdb, 1);
    check({tag, "_busy_at_done"}, bus.busy, 1);
    if (cap_cyc.size() > 0) check({tag, "_done_with_last"}, fd_cyc, cap_cyc[cap_cyc.size()-1]);
    @(posedge sys_clk); #1;
    check({tag, "_busy_drop"}, bus.busy, 0);
  endtask

  task automatic check_outs(input string tag, input int base, input int kind);
    int e0, e1, g0, g1;
    for (int i = 0; i < 6; i++) begin
      case (kind)
        0:       begin e0 = 9; e1 = -9;      end
        1:       begin e0 = 9; e1 = 0;       end
        default: begin e0 = seq0[i]; e1 = seq1[i]; end
      endcase
      g0 = (base + i < cap0.size()) ? cap0[base+i] : -999;
      g1 = (base + i < cap1.size()) ? cap1[base+i] : -999;
      check($sformatf("%s_ch0_%0d", tag, i), g0, e0);
      check($sformatf("%s_ch1_%0d", tag, i), g1, e1);
    end
  endtask

  task automatic run_seq_frame(input string tag);
    int base, fdb;
    base = cap0.size();
    fdb  = fd_cnt;
    w_seq();
    pulse_start(1'b0);
    send_frame(1, 1'b0, 1'b0, IW*IH);
    wait_done(tag, fdb);
    check({tag, "_count"}, cap0.size() - base, 6);
    check_outs(tag, base, 2);
    if (cap_cyc.size() > base) check({tag, "_latency"}, cap_cyc[base] - acc22, 3);
  endtask

  initial begin
    int base, fdb;
    bus.start     = 1'b0;
    bus.relu_en   = 1'b0;
    bus.weights   = '0;
    bus.pix_in    = '0;
    bus.pix_valid = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_data_out", bus.data_out, 0);
    check("rst_frame_done", bus.frame_done, 0);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;

    // 1: ones, +1/-1 weights
    base = cap0.size(); fdb = fd_cnt;
    w_pm1();
    pulse_start(1'b0);
    check("s1_busy_run", bus.busy, 1);
    send_frame(0, 1'b0, 1'b0, IW*IH);
    wait_done("s1", fdb);
    check("s1_count", cap0.size() - base, 6);
    check_outs("s1", base, 0);

    // 2: same with ReLU, started the cycle after the previous frame_done
    base = cap0.size(); fdb = fd_cnt;
    pulse_start(1'b1);
    send_frame(0, 1'b0, 1'b0, IW*IH);
    wait_done("s2", fdb);
    check("s2_count", cap0.size() - base, 6);
    check_outs("s2", base, 1);

    // 3: ramp pixels, centre tap and top-left tap
    run_seq_frame("s3");

    // 4: gapped input, weights zeroed and start pulsed mid-frame
    base = cap0.size(); fdb = fd_cnt;
    w_seq();
    pulse_start(1'b0);
    send_frame(1, 1'b1, 1'b1, IW*IH);
    wait_done("s4", fdb);
    repeat (10) @(posedge sys_clk);
    #1;
    check("s4_single_done", fd_cnt - fdb, 1);
    check("s4_count", cap0.size() - base, 6);
    check_outs("s4", base, 2);

    // 5: reset after 9 pixels, then a clean frame
    base = cap0.size(); fdb = fd_cnt;
    w_seq();
    pulse_start(1'b0);
    send_frame(1, 1'b0, 1'b0, 9);
    sys_rst = 1'b1;
    #1;
    check("s5_busy", bus.busy, 0);
    check("s5_out_valid", bus.out_valid, 0);
    check("s5_data_out", bus.data_out, 0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    repeat (8) @(posedge sys_clk);
    #1;
    check("s5_no_done", fd_cnt - fdb, 0);
    check("s5_no_outputs", cap0.size() - base, 0);
    run_seq_frame("s5r");

    // 6: back-to-back frames; weights changed during frame 1 only affect frame 2
    base = cap0.size(); fdb = fd_cnt;
    w_seq();
    pulse_start(1'b0);
    w_pm1();
    send_frame(1, 1'b0, 1'b0, IW*IH);
    wait_done("s6a", fdb);
    pulse_start(1'b0);
    send_frame(0, 1'b0, 1'b0, IW*IH);
    wait_done("s6b", fdb + 1);
    check("s6_count", cap0.size() - base, 12);
    check("s6_dones", fd_cnt - fdb, 2);
    check_outs("s6a", base, 2);
    check_outs("s6b", base + 6, 0);

    check("orphan_frame_done", orphan_fd, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
